retire_wide: RTL

Parametrised N-wide in-order retirement unit; successor to the single-wide retire/ROB pair. It allocates ROB entries from rename and accepts completions from NUM_WB writeback ports. It retires up to RETIRE_WIDTH oldest completed entries per cycle, returning their superseded physical registers to the free list. A mispredicted branch at retirement flushes the whole window and redirects fetch.

---
 rtl/retire_wide_pkg.sv | 34 +++
 rtl/retire_wide_sel.sv | 40 ++++
 rtl/retire_wide.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/retire_wide_pkg.sv
// Shared types for the N-wide in-order retirement unit: ROB IDs, entry layout,
// retire FSM states and the pointer fullness helper.
package retire_wide_pkg;

  localparam int unsigned ROB_DEPTH_MAX = 32;
  localparam int unsigned ROB_ID_W      = $clog2(ROB_DEPTH_MAX) + 1;
  localparam int unsigned PRF_ID_W      = 7;
  localparam int unsigned PADDR_W       = 32;

  typedef logic [ROB_ID_W-1:0] t_rob_id;
  typedef logic [PRF_ID_W-1:0] t_prf_id;
  typedef logic [PADDR_W-1:0]  t_paddr;

  typedef struct packed {
    logic    valid;
    logic    complete;
    logic    mispred;
    logic    has_dst;
    t_prf_id prev_prf;
    t_paddr  tgt;
  } t_rob_wide_entry;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } t_retire_state;

  // Full when index bits match and the wrap bit (bit idx_w) differs.
  function automatic logic rob_id_full(input t_rob_id head, input t_rob_id tail,
                                       input int unsigned idx_w);
    return (head ^ tail) == (t_rob_id'(1) << idx_w);
  endfunction

endpackage

// File: rtl/retire_wide_sel.sv
// Combinational prefix-AND retire picker: slot i retires only if every older
// slot retires and none of them is a mispredicted branch.
module retire_wide_sel
  import retire_wide_pkg::*;
#(
  parameter  int unsigned RETIRE_WIDTH = 2,
  localparam int unsigned CNT_W        = $clog2(RETIRE_WIDTH + 1),
  localparam int unsigned SLOT_W       = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1
) (
  input  logic [RETIRE_WIDTH-1:0] slot_valid,
  input  logic [RETIRE_WIDTH-1:0] slot_complete,
  input  logic [RETIRE_WIDTH-1:0] slot_mispred,
  output logic [RETIRE_WIDTH-1:0] retire_mask,
  output logic [CNT_W-1:0]        retire_cnt,
  output logic                    mispred_any,
  output logic [SLOT_W-1:0]       mispred_slot
);

  always_comb begin
    logic go;
    go           = 1'b1;
    retire_mask  = '0;
    retire_cnt   = '0;
    mispred_any  = 1'b0;
    mispred_slot = '0;
    for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
      retire_mask[i] = go & slot_valid[i] & slot_complete[i];
      if (retire_mask[i]) begin
        retire_cnt = retire_cnt + CNT_W'(1);
        if (slot_mispred[i]) begin
          mispred_any  = 1'b1;
          mispred_slot = SLOT_W'(i);
        end
      end
      // A mispredicted slot still retires but blocks every younger slot.
      go = retire_mask[i] & ~slot_mispred[i];
    end
  end

endmodule

// File: rtl/retire_wide.sv
// N-wide in-order retirement unit: allocates ROB entries, takes NUM_WB
// completions, retires up to RETIRE_WIDTH per cycle and flushes on mispredict.
module retire_wide
  import retire_wide_pkg::*;
#(
  parameter  int unsigned ROB_DEPTH    = 32,
  parameter  int unsigned RETIRE_WIDTH = 2,
  parameter  int unsigned NUM_WB       = 2,
  localparam int unsigned CNT_W        = $clog2(RETIRE_WIDTH + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           alloc_valid_ra0,
  input  logic                           alloc_has_dst_ra0,
  input  t_prf_id                        alloc_prev_prf_ra0,
  output logic                           alloc_ready_ra0,
  output t_rob_id                        alloc_robid_ra0,
  input  logic    [NUM_WB-1:0]           wb_valid_rb0,
  input  t_rob_id [NUM_WB-1:0]           wb_robid_rb0,
  input  logic    [NUM_WB-1:0]           wb_mispred_rb0,
  input  t_paddr  [NUM_WB-1:0]           wb_tgt_rb0,
  output logic    [RETIRE_WIDTH-1:0]     reclaim_valid_rb1,
  output t_prf_id [RETIRE_WIDTH-1:0]     reclaim_prf_id_rb1,
  output logic    [CNT_W-1:0]            retire_cnt_rb1,
  output logic                           br_mispred_rb1,
  output t_paddr                         br_tgt_rb1
);

  localparam int unsigned IDX_W  = $clog2(ROB_DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned SLOT_W = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1;

  if (ROB_DEPTH > ROB_DEPTH_MAX || ROB_DEPTH < 2 * RETIRE_WIDTH ||
      (ROB_DEPTH & (ROB_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("retire_wide: ROB_DEPTH must be a power of two in [2*RETIRE_WIDTH, ROB_DEPTH_MAX]");
  end

  typedef logic [PTR_W-1:0] t_ptr;
  typedef logic [IDX_W-1:0] t_idx;

  t_retire_state                 state_q, state_d;
  t_ptr                          head_q, head_d, tail_q, tail_d;
  t_rob_wide_entry               rob_q [ROB_DEPTH];
  t_rob_wide_entry               rob_d [ROB_DEPTH];
  logic    [RETIRE_WIDTH-1:0]    reclaim_valid_q, reclaim_valid_d;
  t_prf_id [RETIRE_WIDTH-1:0]    reclaim_prf_id_q, reclaim_prf_id_d;
  logic    [CNT_W-1:0]           retire_cnt_q, retire_cnt_d;
  logic                          br_mispred_q, br_mispred_d;
  t_paddr                        br_tgt_q, br_tgt_d;

  logic                          run, full;
  t_idx                          slot_idx [RETIRE_WIDTH];
  logic [RETIRE_WIDTH-1:0]       slot_valid, slot_complete, slot_mispred, ret_mask;
  logic [CNT_W-1:0]              ret_cnt;
  logic                          mis_any;
  logic [SLOT_W-1:0]             mis_slot;

  assign run             = (state_q == RUN);
  assign full            = rob_id_full(t_rob_id'(head_q), t_rob_id'(tail_q), IDX_W);
  assign alloc_ready_ra0 = reset && run && !full;
  assign alloc_robid_ra0 = t_rob_id'(tail_q);

  // Slots are gated off during FLUSH so stale younger entries cannot retire.
  always_comb begin
    for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
      slot_idx[i]      = head_q[IDX_W-1:0] + t_idx'(i);
      slot_valid[i]    = run && rob_q[slot_idx[i]].valid;
      slot_complete[i] = rob_q[slot_idx[i]].complete;
      slot_mispred[i]  = rob_q[slot_idx[i]].mispred;
    end
  end

  retire_wide_sel #(
    .RETIRE_WIDTH(RETIRE_WIDTH)
  ) u_sel (
    .slot_valid   (slot_valid),
    .slot_complete(slot_complete),
    .slot_mispred (slot_mispred),
    .retire_mask  (ret_mask),
    .retire_cnt   (ret_cnt),
    .mispred_any  (mis_any),
    .mispred_slot (mis_slot)
  );

  always_comb begin
    t_ptr wb_ptr;
    t_ptr occ;
    state_d          = state_q;
    head_d           = head_q;
    tail_d           = tail_q;
    rob_d            = rob_q;
    reclaim_valid_d  = '0;
    reclaim_prf_id_d = '0;
    retire_cnt_d     = '0;
    br_mispred_d     = 1'b0;
    br_tgt_d         = '0;
    wb_ptr           = '0;
    occ              = tail_q - head_q;

    if (!run) begin
      for (int unsigned k = 0; k < ROB_DEPTH; k++) begin
        rob_d[k].valid = 1'b0;
      end
      tail_d  = head_q;
      state_d = RUN;
    end else begin
      if (alloc_valid_ra0 && alloc_ready_ra0) begin
        rob_d[tail_q[IDX_W-1:0]] = '{valid: 1'b1, complete: 1'b0, mispred: 1'b0,
                                    has_dst: alloc_has_dst_ra0,
                                    prev_prf: alloc_prev_prf_ra0, tgt: '0};
        tail_d = tail_q + t_ptr'(1);
      end

      // Walk ports from highest to lowest so port 0 has the final say.
      for (int unsigned k = 0; k < NUM_WB; k++) begin
        wb_ptr = wb_robid_rb0[NUM_WB-1-k][PTR_W-1:0];
        if (wb_valid_rb0[NUM_WB-1-k] &&
            wb_robid_rb0[NUM_WB-1-k] == t_rob_id'(wb_ptr) &&
            t_ptr'(wb_ptr - head_q) < occ &&
            rob_q[wb_ptr[IDX_W-1:0]].valid) begin
          rob_d[wb_ptr[IDX_W-1:0]].complete = 1'b1;
          rob_d[wb_ptr[IDX_W-1:0]].mispred  = wb_mispred_rb0[NUM_WB-1-k];
          rob_d[wb_ptr[IDX_W-1:0]].tgt      = wb_tgt_rb0[NUM_WB-1-k];
        end
      end

      for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
        if (ret_mask[i]) begin
          rob_d[slot_idx[i]].valid = 1'b0;
          reclaim_valid_d[i]       = rob_q[slot_idx[i]].has_dst;
          reclaim_prf_id_d[i]      = rob_q[slot_idx[i]].has_dst ?
                                     rob_q[slot_idx[i]].prev_prf : '0;
        end
      end
      head_d       = head_q + t_ptr'(ret_cnt);
      retire_cnt_d = ret_cnt;
      if (mis_any) begin
        br_mispred_d = 1'b1;
        br_tgt_d     = rob_q[slot_idx[mis_slot]].tgt;
        state_d      = FLUSH;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= RUN;
      head_q           <= '0;
      tail_q           <= '0;
      for (int unsigned k = 0; k < ROB_DEPTH; k++) begin
        rob_q[k] <= '0;
      end
      reclaim_valid_q  <= '0;
      reclaim_prf_id_q <= '0;
      retire_cnt_q     <= '0;
      br_mispred_q     <= 1'b0;
      br_tgt_q         <= '0;
    end else begin
      state_q          <= state_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      rob_q            <= rob_d;
      reclaim_valid_q  <= reclaim_valid_d;
      reclaim_prf_id_q <= reclaim_prf_id_d;
      retire_cnt_q     <= retire_cnt_d;
      br_mispred_q     <= br_mispred_d;
      br_tgt_q         <= br_tgt_d;
    end
  end

  assign reclaim_valid_rb1  = reclaim_valid_q;
  assign reclaim_prf_id_rb1 = reclaim_prf_id_q;
  assign retire_cnt_rb1     = retire_cnt_q;
  assign br_mispred_rb1     = br_mispred_q;
  assign br_tgt_rb1         = br_tgt_q;

endmodule
